rr_onehot_arbiter: RTL and testbench
====================================

// Module: rr_onehot_arbiter
// PURPOSE
//   Round-robin request arbiter; sits directly upstream of the 8-to-3 encoder.
//   Collects sticky request pulses from up to 8 sources and issues exactly one
//   one-hot grant at a time over a valid/ready handshake.
//   grant_onehot is wired to the encoder input, which never sees a multi-hot
//   or zero vector while grant_valid=1.
// PARAMETERS
//   N      8   number of request sources, equal to the encoder input width (N>=2)
// PORTS
//   clk           in   1   single clock; all state updates on the rising edge
//   rst           in   1   synchronous, active-high reset
//   req           in   N   request pulses, one bit per source; level or pulse
//   grant_ready   in   1   consumer accepts the current grant this cycle
//   grant_valid   out  1   grant_onehot holds a valid grant
//   grant_onehot  out  N   one-hot grant vector, fed to the encoder
//   pending       out  N   registered sticky request vector (status)
//   req_dropped   out  1   1-cycle pulse: a req bit hit an already-pending bit
// BEHAVIOUR
//   Reset (rst=1 at an edge): pending=0, grant_onehot=0, grant_valid=0,
//     req_dropped=0, last-grant pointer ptr=N-1, state=IDLE.
//     rst overrides any in-flight grant; no handshake completes in that cycle.
//   Pending update each edge:
//     pending <= (pending & ~clr) | req
//     clr = grant_onehot when grant_valid && grant_ready, else 0.
//     If req[i] is asserted in the same cycle that bit i is cleared, bit i stays
//     set as a new request. This is not a drop.
//   Drop: req_dropped <= |(req & pending & ~clr). The request is merged and not
//     counted again.
//   Pick function: the first set bit of pending scanning ptr+1, ptr+2, ...,
//     wrapping N-1 -> 0. Result is one-hot, or 0 if pending==0.
//   FSM states: IDLE, OFFER.
//     IDLE: if pending!=0, register grant_onehot=pick(pending), set
//       grant_valid=1, go to OFFER. Otherwise stay in IDLE with grant_onehot=0.
//     OFFER: grant_onehot and grant_valid are held stable until grant_ready=1.
//       On handshake: ptr <= index of the granted bit.
//       If pending & ~clr is nonzero, register the next pick immediately
//       (back-to-back, evaluated with the new ptr) and stay in OFFER.
//       Otherwise set grant_valid=0, grant_onehot=0, go to IDLE.
//     grant_ready is ignored while grant_valid=0.
//   Latency: req sampled at edge E. pending is visible after E. grant_valid
//     rises after E+1 when the FSM was idle. Throughput is 1 grant per cycle
//     when grant_ready=1 continuously.
//   Fairness: after granting i, every other pending source is granted before
//     i is granted again.
//   Invariant: grant_valid -> $onehot(grant_onehot) and
//     (grant_onehot & pending) != 0.
// STRUCTURE
//   Package arb_pkg:
//     localparam ARB_N = 8
//     typedef enum logic {IDLE, OFFER} arb_state_t
//     function onehot2idx
//   Sub-module rr_pick: purely combinational rotate / priority-find / unrotate.
//     Inputs: pending[N], ptr[$clog2(N)]. Output: onehot[N].
//   Top level holds the registers, FSM, and drop logic.
// TESTING
//   1 Reset: rst=1 for 2 cycles with req=8'hFF.
//     -> grant_valid=0, pending=0, req_dropped=0.
//     After release, the first grant is 8'b0000_0001.
//   2 Single request: req=8'h08 for 1 cycle, grant_ready=1.
//     -> grant_valid=1 with grant_onehot=8'h08 two edges later; encoder
//     out=3'd3. Next cycle grant_valid=0 and pending=0.
//   3 Round-robin: req=8'hA5 for 1 cycle, grant_ready=1.
//     -> grant sequence 01,04,20,80 on consecutive cycles, then idle.
//   4 Backpressure: grant_ready=0 for 5 cycles while grant_onehot=8'h02.
//     -> grant is held stable. Asserting req[1] again -> req_dropped=1 for
//     one cycle.
//   5 Wrap and re-request: ptr=7 and pending=8'h81.
//     -> grant 8'h01, then 8'h80.
//     req[0] asserted in the cycle grant 01 is accepted -> bit 0 remains
//     pending and is granted after 80.
//   6 Mid-operation reset: rst=1 while grant_valid=1, grant_ready=1.
//     -> no further grants are issued, all outputs return to reset values,
//     and ptr restarts at 7.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared types and helpers for the round-robin one-hot arbiter.
package arb_pkg;

  localparam int ARB_N = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } arb_state_t;

  // Index of the set bit of a one-hot vector (up to 32 bits wide).
  // Returns 0 for an all-zero vector.
  function automatic int unsigned onehot2idx(input logic [31:0] oh);
    int unsigned idx;
    idx = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if (oh[i]) idx = idx | i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin pick: first set bit of pending, scanning from ptr+1 upward
// with wrap from N-1 to 0. Produces a one-hot vector, or zero if pending==0.
module rr_pick
  import arb_pkg::*;
#(
  parameter int N  = ARB_N,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  pending,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  onehot
);

  // Rotate / priority-find / unrotate folded into one wrapped scan.
  always_comb begin
    logic        found;
    int unsigned base;
    int unsigned idx;
    onehot = '0;
    found  = 1'b0;
    base   = 32'(ptr) + 1;
    for (int unsigned k = 0; k < N; k++) begin
      idx = base + k;
      if (idx >= N) idx = idx - N;
      if (!found && pending[idx]) begin
        onehot[idx] = 1'b1;
        found       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rr_onehot_arbiter.sv
// Round-robin request arbiter feeding the 8-to-3 encoder. Collects sticky
// requests and offers one one-hot grant at a time over valid/ready.
module rr_onehot_arbiter
  import arb_pkg::*;
#(
  parameter int N = ARB_N
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         grant_ready,
  output logic         grant_valid,
  output logic [N-1:0] grant_onehot,
  output logic [N-1:0] pending,
  output logic         req_dropped
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  arb_state_t  state_q, state_d;
  logic [PW-1:0] ptr_q, ptr_d;
  logic [N-1:0]  pending_q, pending_d;
  logic [N-1:0]  grant_onehot_q, grant_onehot_d;
  logic          grant_valid_q, grant_valid_d;
  logic          req_dropped_q, req_dropped_d;

  logic          hs;
  logic [N-1:0]  clr;
  logic [N-1:0]  remain;
  logic [PW-1:0] hs_ptr;
  logic [N-1:0]  pick_idle;
  logic [N-1:0]  pick_next;

  // Pick from the registered pending set using the current pointer (IDLE).
  rr_pick #(.N(N), .PW(PW)) u_pick_idle (
    .pending (pending_q),
    .ptr     (ptr_q),
    .onehot  (pick_idle)
  );

  // Back-to-back pick: what remains after the handshake, scanned from the
  // just-granted index so the next grant uses the updated pointer.
  rr_pick #(.N(N), .PW(PW)) u_pick_next (
    .pending (remain),
    .ptr     (hs_ptr),
    .onehot  (pick_next)
  );

  // Handshake, pending/drop update and FSM next state.
  always_comb begin
    hs            = grant_valid_q && grant_ready;
    clr           = hs ? grant_onehot_q : '0;
    remain        = pending_q & ~clr;
    pending_d     = remain | req;
    req_dropped_d = |(req & pending_q & ~clr);
    hs_ptr        = PW'(onehot2idx(32'(grant_onehot_q)));

    state_d        = state_q;
    ptr_d          = ptr_q;
    grant_onehot_d = grant_onehot_q;
    grant_valid_d  = grant_valid_q;

    unique case (state_q)
      IDLE: begin
        if (|pending_q) begin
          grant_onehot_d = pick_idle;
          grant_valid_d  = 1'b1;
          state_d        = OFFER;
        end else begin
          grant_onehot_d = '0;
          grant_valid_d  = 1'b0;
        end
      end
      OFFER: begin
        if (hs) begin
          ptr_d = hs_ptr;
          if (|remain) begin
            grant_onehot_d = pick_next;
          end else begin
            grant_onehot_d = '0;
            grant_valid_d  = 1'b0;
            state_d        = IDLE;
          end
        end
      end
      default: begin
        state_d        = IDLE;
        grant_onehot_d = '0;
        grant_valid_d  = 1'b0;
      end
    endcase
  end

  // State registers with synchronous reset; reset wins over any handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      ptr_q          <= PW'(N - 1);
      pending_q      <= '0;
      grant_onehot_q <= '0;
      grant_valid_q  <= 1'b0;
      req_dropped_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      ptr_q          <= ptr_d;
      pending_q      <= pending_d;
      grant_onehot_q <= grant_onehot_d;
      grant_valid_q  <= grant_valid_d;
      req_dropped_q  <= req_dropped_d;
    end
  end

  assign grant_valid  = grant_valid_q;
  assign grant_onehot = grant_onehot_q;
  assign pending      = pending_q;
  assign req_dropped  = req_dropped_q;

endmodule

// File: tb/tb_rr_onehot_arbiter.sv
// Directed bench for rr_onehot_arbiter with hand-computed expectations.
module tb_rr_onehot_arbiter;

  logic       clk;
  logic       rst;
  logic [7:0] req;
  logic       grant_ready;
  logic       grant_valid;
  logic [7:0] grant_onehot;
  logic [7:0] pending;
  logic       req_dropped;

  int unsigned vec_cnt;
  int unsigned err_cnt;

  rr_onehot_arbiter #(.N(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .req          (req),
    .grant_ready  (grant_ready),
    .grant_valid  (grant_valid),
    .grant_onehot (grant_onehot),
    .pending      (pending),
    .req_dropped  (req_dropped)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // Advance one edge, then sample just after it; check the grant invariant.
  task automatic step();
    @(posedge clk);
    #1;
    if (grant_valid === 1'b1) begin
      chk("inv_onehot", 32'($onehot(grant_onehot)), 32'd1);
      chk("inv_in_pending", 32'(|(grant_onehot & pending)), 32'd1);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; req = '0; grant_ready = 1'b0;
    step(); step();
    rst = 1'b0;
  endtask

  initial begin
    vec_cnt = 0;
    err_cnt = 0;
    rst = 1'b1; req = 8'hFF; grant_ready = 1'b0;

    // 1: reset with all requests high
    step(); step();
    chk("rst_valid", 32'(grant_valid), 32'd0);
    chk("rst_pending", 32'(pending), 32'd0);
    chk("rst_dropped", 32'(req_dropped), 32'd0);
    chk("rst_grant", 32'(grant_onehot), 32'd0);
    rst = 1'b0;
    step();
    chk("t1_pending", 32'(pending), 32'hFF);
    chk("t1_valid0", 32'(grant_valid), 32'd0);
    req = '0; grant_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      chk("t1_seq_valid", 32'(grant_valid), 32'd1);
      chk("t1_seq_grant", 32'(grant_onehot), 32'd1 << i);
    end
    step();
    chk("t1_drain_valid", 32'(grant_valid), 32'd0);
    chk("t1_drain_pending", 32'(pending), 32'd0);

    // 2: single request
    do_reset();
    grant_ready = 1'b1; req = 8'h08;
    step();
    chk("t2_valid_e1", 32'(grant_valid), 32'd0);
    req = '0;
    step();
    chk("t2_valid", 32'(grant_valid), 32'd1);
    chk("t2_grant", 32'(grant_onehot), 32'h08);
    step();
    chk("t2_idle_valid", 32'(grant_valid), 32'd0);
    chk("t2_idle_pending", 32'(pending), 32'd0);

    // 3: round-robin order from reset pointer
    do_reset();
    grant_ready = 1'b1; req = 8'hA5;
    step();
    req = '0;
    step(); chk("t3_g0", 32'(grant_onehot), 32'h01);
    step(); chk("t3_g1", 32'(grant_onehot), 32'h04);
    step(); chk("t3_g2", 32'(grant_onehot), 32'h20);
    step(); chk("t3_g3", 32'(grant_onehot), 32'h80);
    step(); chk("t3_idle", 32'(grant_valid), 32'd0);

    // 4: backpressure holds grant; re-request of pending bit is dropped
    do_reset();
    grant_ready = 1'b0; req = 8'h02;
    step();
    req = '0;
    step();
    for (int i = 0; i < 5; i++) begin
      req = (i == 2) ? 8'h02 : 8'h00;
      step();
      chk("t4_hold_valid", 32'(grant_valid), 32'd1);
      chk("t4_hold_grant", 32'(grant_onehot), 32'h02);
      chk("t4_dropped", 32'(req_dropped), (i == 2) ? 32'd1 : 32'd0);
    end
    req = '0; grant_ready = 1'b1;
    step();
    chk("t4_release_valid", 32'(grant_valid), 32'd0);
    chk("t4_release_pending", 32'(pending), 32'd0);

    // 5: wrap with re-request on accept
    do_reset();
    grant_ready = 1'b0; req = 8'h81;
    step();
    req = '0;
    step();
    chk("t5_g0", 32'(grant_onehot), 32'h01);
    grant_ready = 1'b1; req = 8'h01;
    step();
    chk("t5_g1", 32'(grant_onehot), 32'h80);
    chk("t5_pend1", 32'(pending), 32'h81);
    chk("t5_nodrop", 32'(req_dropped), 32'd0);
    req = '0;
    step();
    chk("t5_g2", 32'(grant_onehot), 32'h01);
    chk("t5_pend2", 32'(pending), 32'h01);
    step();
    chk("t5_idle", 32'(grant_valid), 32'd0);

    // 6: reset during an active handshake
    do_reset();
    grant_ready = 1'b1; req = 8'hFF;
    step();
    req = '0;
    step(); chk("t6_g0", 32'(grant_onehot), 32'h01);
    step(); chk("t6_g1", 32'(grant_onehot), 32'h02);
    rst = 1'b1;
    step();
    chk("t6_rst_valid", 32'(grant_valid), 32'd0);
    chk("t6_rst_grant", 32'(grant_onehot), 32'd0);
    chk("t6_rst_pending", 32'(pending), 32'd0);
    chk("t6_rst_dropped", 32'(req_dropped), 32'd0);
    step();
    chk("t6_rst_hold", 32'(grant_valid), 32'd0);
    rst = 1'b0; req = 8'hFF;
    step();
    req = '0;
    step();
    chk("t6_ptr_restart", 32'(grant_onehot), 32'h01);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
